pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing stage sitting directly downstream of the jump-target lookup table.
- Drives the 5-bit LUT index from decode's jump field and consumes the 8-bit Target the LUT returns.
- Computes the next PC: sequential, absolute jump or PC-relative branch.
- Owns the run/halt state machine and the cycle and taken-branch counters.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/pc_next_calc.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 101 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, start address and state encoding for the fetch stage
package fetch_pkg;

  localparam int PC_W     = 10;
  localparam int TGT_W    = 8;
  localparam int IDX_W    = 5;
  localparam int CNT_W    = 16;
  localparam int START_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC select: hold, absolute, PC-relative or sequential
module pc_next_calc #(
  parameter int PC_W  = 10,
  parameter int TGT_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [TGT_W-1:0] target,
  input  logic             branch_en,
  input  logic             branch_abs,
  input  logic             taken,
  input  logic             stall,
  output logic [PC_W-1:0]  next_pc,
  output logic             branch_taken
);

  logic [PC_W-1:0] tgt_zext;
  logic [PC_W-1:0] tgt_sext;

  assign tgt_zext     = {{(PC_W-TGT_W){1'b0}}, target};
  assign tgt_sext     = {{(PC_W-TGT_W){target[TGT_W-1]}}, target};
  // A stalled branch is dropped here; decode presents it again once the stall clears.
  assign branch_taken = branch_en & taken & ~stall;

  always_comb begin
    next_pc = pc + 1'b1;
    if (stall) begin
      next_pc = pc;
    end else if (branch_taken) begin
      next_pc = branch_abs ? tgt_zext : pc + tgt_sext;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, run/halt FSM and cycle/branch counters of the fetch stage
module pc_fetch_ctrl #(
  parameter int PC_W     = fetch_pkg::PC_W,
  parameter int TGT_W    = fetch_pkg::TGT_W,
  parameter int IDX_W    = fetch_pkg::IDX_W,
  parameter int START_PC = fetch_pkg::START_PC,
  parameter int CNT_W    = fetch_pkg::CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             HaltReq,
  input  logic             BranchEn,
  input  logic             BranchAbs,
  input  logic             Taken,
  input  logic [IDX_W-1:0] JumpIdx,
  output logic [IDX_W-1:0] LutAddr,
  input  logic [TGT_W-1:0] Target,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] BranchCnt
);

  import fetch_pkg::*;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [PC_W-1:0]  calc_pc;
  logic             branch_taken;
  logic [PC_W-1:0]  start_pc;

  assign start_pc = START_PC[PC_W-1:0];
  assign LutAddr  = JumpIdx;

  pc_next_calc #(
    .PC_W  (PC_W),
    .TGT_W (TGT_W)
  ) u_next (
    .pc           (pc_q),
    .target       (Target),
    .branch_en    (BranchEn),
    .branch_abs   (BranchAbs),
    .taken        (Taken),
    .stall        (Stall),
    .next_pc      (calc_pc),
    .branch_taken (branch_taken)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cycle_cnt_d  = cycle_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (Start) begin
      state_d      = ST_RUN;
      pc_d         = start_pc;
      cycle_cnt_d  = '0;
      branch_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // The halting cycle still counts as a RUN cycle.
          if (!(&cycle_cnt_q)) cycle_cnt_d = cycle_cnt_q + 1'b1;
          if (HaltReq) begin
            state_d = ST_DONE;
          end else begin
            pc_d = calc_pc;
            if (branch_taken && !(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      cycle_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign PC        = pc_q;
  assign Running   = (state_q == ST_RUN);
  assign Done      = (state_q == ST_DONE);
  assign CycleCnt  = cycle_cnt_q;
  assign BranchCnt = branch_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed vector bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, HaltReq, BranchEn, BranchAbs, Taken;
  logic [4:0]  JumpIdx, LutAddr;
  logic [7:0]  Target;
  logic [9:0]  PC;
  logic        Running, Done;
  logic [15:0] CycleCnt, BranchCnt;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_fetch_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Stall     (Stall),
    .HaltReq   (HaltReq),
    .BranchEn  (BranchEn),
    .BranchAbs (BranchAbs),
    .Taken     (Taken),
    .JumpIdx   (JumpIdx),
    .LutAddr   (LutAddr),
    .Target    (Target),
    .PC        (PC),
    .Running   (Running),
    .Done      (Done),
    .CycleCnt  (CycleCnt),
    .BranchCnt (BranchCnt)
  );

  typedef struct {
    logic        rst, start, stall, halt, ben, babs, taken;
    logic [4:0]  idx;
    logic [7:0]  tgt;
    logic [9:0]  pc;
    logic        run, done;
    logic [15:0] cyc, br;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, start, stall, halt, ben, babs, taken,
                     input logic [4:0] idx, input logic [7:0] tgt,
                     input logic [9:0] pc, input logic run, done,
                     input logic [15:0] cyc, br);
    vec_t v;
    v.rst = rst; v.start = start; v.stall = stall; v.halt = halt;
    v.ben = ben; v.babs = babs; v.taken = taken; v.idx = idx; v.tgt = tgt;
    v.pc = pc; v.run = run; v.done = done; v.cyc = cyc; v.br = br;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, start, stall, halt, ben, babs, taken,
                       input logic [4:0] idx, input logic [7:0] tgt);
    Reset = rst; Start = start; Stall = stall; HaltReq = halt;
    BranchEn = ben; BranchAbs = babs; Taken = taken; JumpIdx = idx; Target = tgt;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_pc", -1, PC, 0);
    chk("reset_run", -1, Running, 0);
    chk("reset_done", -1, Done, 0);
    chk("reset_cyc", -1, CycleCnt, 0);
    chk("reset_br", -1, BranchCnt, 0);

    //  rst st sl ht be ab tk idx    tgt     | pc      run dn cyc br
    add(0, 0, 1, 1, 1, 1, 1, 5'd3, 8'h55,  10'h000, 0, 0, 0,  0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h000, 1, 0, 0,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h001, 1, 0, 1,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h002, 1, 0, 2,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h003, 1, 0, 3,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h004, 1, 0, 4,  0);
    add(0, 0, 0, 0, 1, 1, 1, 5'd2, 8'h78,  10'h078, 1, 0, 5,  1);
    add(0, 0, 0, 0, 1, 0, 1, 5'd7, 8'hFC,  10'h074, 1, 0, 6,  2);
    add(0, 0, 0, 0, 1, 0, 1, 5'd8, 8'h80,  10'h3F4, 1, 0, 7,  3);
    add(0, 0, 0, 0, 1, 0, 1, 5'd9, 8'h0A,  10'h3FE, 1, 0, 8,  4);
    add(0, 0, 0, 0, 1, 0, 1, 5'd10, 8'h04, 10'h002, 1, 0, 9,  5);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h003, 1, 0, 10, 5);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h004, 1, 0, 11, 5);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h005, 1, 0, 12, 5);
    add(0, 0, 0, 0, 1, 1, 0, 5'd4, 8'h40,  10'h006, 1, 0, 13, 5);
    add(0, 0, 1, 0, 1, 1, 1, 5'd6, 8'h09,  10'h006, 1, 0, 14, 5);
    add(0, 0, 0, 0, 1, 1, 1, 5'd6, 8'h09,  10'h009, 1, 0, 15, 6);
    add(0, 0, 0, 1, 1, 0, 1, 5'd1, 8'h10,  10'h009, 0, 1, 16, 6);
    for (int i = 0; i < 10; i++)
      add(0, 0, i[0], i[1], 1, i[2], 1, 5'(i), 8'(i * 7), 10'h009, 0, 1, 16, 6);
    add(0, 1, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h000, 1, 0, 0,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h001, 1, 0, 1,  0);
    add(0, 1, 1, 1, 1, 1, 1, 5'd11, 8'h22, 10'h000, 1, 0, 0,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'h00,  10'h001, 1, 0, 1,  0);
    add(0, 0, 0, 0, 1, 1, 1, 5'd12, 8'h33, 10'h033, 1, 0, 2,  1);
    add(1, 1, 0, 0, 1, 1, 1, 5'd13, 8'h44, 10'h000, 0, 0, 0,  0);
    add(0, 0, 0, 0, 1, 0, 1, 5'd14, 8'h05, 10'h000, 0, 0, 0,  0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].ben,
            vecs[i].babs, vecs[i].taken, vecs[i].idx, vecs[i].tgt);
      #1;
      chk("lutaddr", i, LutAddr, vecs[i].idx);
      @(posedge Clk);
      #1;
      chk("pc", i, PC, vecs[i].pc);
      chk("running", i, Running, vecs[i].run);
      chk("done", i, Done, vecs[i].done);
      chk("cyclecnt", i, CycleCnt, vecs[i].cyc);
      chk("branchcnt", i, BranchCnt, vecs[i].br);
    end

    // Counter saturation: a taken absolute branch to 0 every cycle bumps both counters.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    drive(0, 0, 0, 0, 1, 1, 1, 0, 8'h00);
    repeat (65534) @(posedge Clk);
    #1;
    chk("sat_cyc_pre", 0, CycleCnt, 16'hFFFE);
    chk("sat_br_pre", 0, BranchCnt, 16'hFFFE);
    repeat (3) @(posedge Clk);
    #1;
    chk("sat_cyc", 0, CycleCnt, 16'hFFFF);
    chk("sat_br", 0, BranchCnt, 16'hFFFF);
    chk("sat_pc", 0, PC, 10'h000);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("sat_cyc_hold", 0, CycleCnt, 16'hFFFF);
    chk("sat_br_hold", 0, BranchCnt, 16'hFFFF);
    chk("sat_pc_seq", 0, PC, 10'h002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
